wb_retire_buffer: RTL and testbench
===================================

// Module: wb_retire_buffer
// PURPOSE
// - In-order retire buffer between W stage and regfile write port; holds load results until RAM data returns.
// - Producer side of the riseW/buf2 forwarding taps read by the E-stage forwarding unit.
// - Raises a load-use stall for decode when a source register hits an entry still awaiting RAM data.
// - Present only when RAMBUFFER and rise are defined in pipeline_config.v.
// PARAMETERS
// - DEPTH  2  entries; power of 2, >=2. riseW/buf2 taps always take the two youngest entries.
// - XLEN   32 data width.
// PORTS
// - clk              in   1     clock; all state on rising edge.
// - rst_n            in   1     async active-low reset.
// - in_valid         in   1     W stage presents a register write.
// - in_ready         out  1     buffer accepts this cycle.
// - in_rd            in   5     destination register.
// - in_data          in   XLEN  result; ignored when in_is_load=1.
// - in_is_load       in   1     data arrives later on mem_rvalid.
// - mem_rvalid       in   1     RAM load data valid; returned in load-issue order.
// - mem_rdata        in   XLEN  load data.
// - rs1_D, rs2_D     in   5     decode-stage sources, for stall check.
// - stall_load_use   out  1     a source matches a not-ready entry.
// - rf_we            out  1     regfile write enable.
// - rf_waddr         out  5     regfile write address.
// - rf_wdata         out  XLEN  regfile write data.
// - RegWrite_riseW   out  1     youngest entry valid, ready, rd!=0.
// - Rd_riseW         out  5     youngest entry rd.
// - rdata_reg_riseW  out  XLEN  youngest entry data.
// - RegWrite_buf2    out  1     second-youngest entry valid, ready, rd!=0.
// - Rd_buf2          out  5     second-youngest entry rd.
// - rdata_reg_buf2   out  XLEN  second-youngest entry data.
// - err_orphan       out  1     sticky: mem_rvalid seen with no pending load.
// BEHAVIOUR
// - Reset (async, rst_n=0): all entries invalid; head/tail/count=0; every output 0 except in_ready=1; err_orphan=0.
//   Reset mid-operation drops buffered writes silently.
// - Entry state: {valid, rdy, rd, data}. Circular FIFO: head = oldest, tail = next free slot.
// - Enqueue: when in_valid && in_ready. rdy=!in_is_load; data=in_data, or 0 for a load.
//   in_rd==0 with in_is_load=0: accepted and discarded (no entry).
//   in_rd==0 load: enqueued, so later data stays in order; never forwarded or written.
// - in_ready = (count<DEPTH) || retire_now. Full buffer accepts when head retires in the same cycle.
// - Load fill: on mem_rvalid, the oldest entry with valid && !rdy takes data=mem_rdata and rdy=1 at the next edge.
//   No such entry: fill ignored; err_orphan set. A load enqueued this cycle is not fill-eligible until the next cycle.
// - Retire (combinational from registered state): retire_now = head.valid && head.rdy.
//   rf_we = retire_now && head.rd!=0; rf_waddr/rf_wdata = head fields.
//   Head pops at the edge. In-order: a not-ready head blocks younger ready entries.
// - Latency: non-load accepted at cycle t is written at t+1 when it is head.
//   Load is written one cycle after its mem_rvalid when it is head.
// - Taps are combinational from registered state. Retiring head stays visible on its tap during its retire cycle.
//   Regfile write is visible to reads from the next cycle on.
// - Tap priority: consumer ranks riseW above buf2. Youngest-first ordering is required for correctness.
// - Stall: stall_load_use = OR over entries of (valid && !rdy && rd!=0 && (rd==rs1_D || rd==rs2_D)).
//   Any pending match stalls, including a younger pending entry shadowing an older ready one (prevents stale buf2 data).
// - Simultaneous events in one cycle: enqueue + retire + fill are all legal. count_next = count + enq - retire.
// - Widths: count is clog2(DEPTH)+1 bits. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
// STRUCTURE
// - RAMBUFFER/rise enables stay in pipeline_config.v. Also add there: `define WB_DEPTH 2 and the entry field widths.
// - One sub-module: wb_rd_match (entry valid/rdy/rd vs rs1/rs2 compare). One instance per entry.
//   Outputs feed the stall OR-tree and the tap-valid logic.
// - Everything else (FIFO pointers, fill select, retire mux) stays inline.
// TESTING
// - Reset: rst_n=0 -> in_ready=1, rf_we=0, taps 0, stall 0, err_orphan 0.
// - ALU write x5=0x1234 at t: rf_we at t+1 with waddr=5, wdata=0x1234; RegWrite_riseW=1 and Rd_riseW=5 in t+1.
// - Load x7 at t; rs1_D=7 -> stall_load_use=1 until mem_rvalid (0xCAFE) at t+3.
//   Then rf_we=1, waddr=7, wdata=0xCAFE at t+4; stall drops at t+4.
// - Load x3 then ALU x3=0x11: ALU entry not written before the load. Stall held while the load is pending.
//   Regfile order x3=load data, then x3=0x11. buf2 never forwards 0x11 ahead of the load.
// - Full (2 pending loads) + in_valid -> in_ready=0. First mem_rvalid -> head ready.
//   Next cycle retire and enqueue together; count stays 2.
// - mem_rvalid with empty buffer -> err_orphan=1 and holds until rst_n=0.
//   Assert rst_n low mid-load -> all state cleared asynchronously.

Source files
------------

// File: rtl/wb_retire_buffer_pkg.sv
// Shared widths, entry metadata layout and helpers for the W-stage retire buffer.
// Pipeline builds that enable the buffer also carry WB_DEPTH and these field widths in their config header.
package wb_retire_buffer_pkg;

  localparam int unsigned WB_REG_W     = 5;
  localparam int unsigned WB_DEPTH_DEF = 2;
  localparam int unsigned WB_XLEN_DEF  = 32;

  typedef struct packed {
    logic                valid;
    logic                rdy;
    logic [WB_REG_W-1:0] rd;
  } wb_meta_t;

  // Entry holds a committed value that may be forwarded or written to the regfile.
  function automatic logic wb_fwd_ok(input wb_meta_t m);
    return m.valid && m.rdy && (m.rd != '0);
  endfunction

endpackage

// File: rtl/wb_rd_match.sv
// Per-entry compare of buffered destination against the decode-stage sources.
module wb_rd_match
  import wb_retire_buffer_pkg::*;
(
  input  wb_meta_t            i_meta,
  input  logic [WB_REG_W-1:0] i_rs1,
  input  logic [WB_REG_W-1:0] i_rs2,
  output logic                o_pend_hit_c,
  output logic                o_fwd_ok_c
);

  logic w_src_hit;

  assign w_src_hit    = (i_meta.rd == i_rs1) || (i_meta.rd == i_rs2);
  // A pending load to x0 never produces a value anyone waits for.
  assign o_pend_hit_c = i_meta.valid && !i_meta.rdy && (i_meta.rd != '0) && w_src_hit;
  assign o_fwd_ok_c   = wb_fwd_ok(i_meta);

endmodule

// File: rtl/wb_retire_buffer.sv
// In-order retire buffer between W stage and the regfile write port; loads wait here
// for RAM data while feeding the riseW/buf2 forwarding taps and the load-use stall.
module wb_retire_buffer
  import wb_retire_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEF,
  parameter int unsigned XLEN  = WB_XLEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WB_REG_W-1:0] in_rd,
  input  logic [XLEN-1:0]     in_data,
  input  logic                in_is_load,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic [WB_REG_W-1:0] rs1_D,
  input  logic [WB_REG_W-1:0] rs2_D,
  output logic                stall_load_use,
  output logic                rf_we,
  output logic [WB_REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                RegWrite_riseW,
  output logic [WB_REG_W-1:0] Rd_riseW,
  output logic [XLEN-1:0]     rdata_reg_riseW,
  output logic                RegWrite_buf2,
  output logic [WB_REG_W-1:0] Rd_buf2,
  output logic [XLEN-1:0]     rdata_reg_buf2,
  output logic                err_orphan
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_meta_t        r_meta [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_err;

  logic            w_retire;
  logic            w_accept;
  logic            w_enq;
  logic            w_fill_hit;
  logic [PW-1:0]   w_fill_idx;
  logic [PW-1:0]   w_young;
  logic [PW-1:0]   w_second;
  logic [DEPTH-1:0] w_pend_hit;
  logic [DEPTH-1:0] w_fwd_ok;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    wb_rd_match u_match (
      .i_meta       (r_meta[g]),
      .i_rs1        (rs1_D),
      .i_rs2        (rs2_D),
      .o_pend_hit_c (w_pend_hit[g]),
      .o_fwd_ok_c   (w_fwd_ok[g])
    );
  end

  assign w_retire = r_meta[r_head].valid && r_meta[r_head].rdy;
  assign in_ready = (r_count < CW'(DEPTH)) || w_retire;
  assign w_accept = in_valid && in_ready;
  // Non-load writes to x0 are dropped; loads to x0 still take a slot to keep RAM returns in order.
  assign w_enq    = w_accept && (in_is_load || (in_rd != '0));

  // Oldest pending load claims the returning RAM data; scan runs youngest to oldest so oldest wins.
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_meta[PW'(r_head + PW'(i))].valid && !r_meta[PW'(r_head + PW'(i))].rdy) begin
        w_fill_hit = 1'b1;
        w_fill_idx = PW'(r_head + PW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_meta[i] <= '0;
        r_data[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_retire) begin
        r_meta[r_head].valid <= 1'b0;
        r_head               <= PW'(r_head + PW'(1));
      end
      if (mem_rvalid && w_fill_hit) begin
        r_meta[w_fill_idx].rdy <= 1'b1;
        r_data[w_fill_idx]     <= mem_rdata;
      end
      // On a full buffer the tail slot is the retiring head, so the enqueue must win.
      if (w_enq) begin
        r_meta[r_tail] <= '{valid: 1'b1, rdy: !in_is_load, rd: in_rd};
        r_data[r_tail] <= in_is_load ? '0 : in_data;
        r_tail         <= PW'(r_tail + PW'(1));
      end
      r_count <= CW'(r_count + CW'(w_enq) - CW'(w_retire));
      if (mem_rvalid && !w_fill_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rf_we    = w_retire && (r_meta[r_head].rd != '0);
  assign rf_waddr = r_meta[r_head].rd;
  assign rf_wdata = r_data[r_head];

  assign w_young  = PW'(r_tail - PW'(1));
  assign w_second = PW'(r_tail - PW'(2));

  assign RegWrite_riseW  = w_fwd_ok[w_young];
  assign Rd_riseW        = r_meta[w_young].rd;
  assign rdata_reg_riseW = r_data[w_young];
  assign RegWrite_buf2   = w_fwd_ok[w_second];
  assign Rd_buf2         = r_meta[w_second].rd;
  assign rdata_reg_buf2  = r_data[w_second];

  assign stall_load_use = |w_pend_hit;
  assign err_orphan     = r_err;

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Directed self-checking bench for wb_retire_buffer: reset, ALU/load latency, ordering, full and orphan cases.
module tb_wb_retire_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        in_is_load;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_D;
  logic [4:0]  rs2_D;
  logic        stall_load_use;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        RegWrite_riseW;
  logic [4:0]  Rd_riseW;
  logic [31:0] rdata_reg_riseW;
  logic        RegWrite_buf2;
  logic [4:0]  Rd_buf2;
  logic [31:0] rdata_reg_buf2;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;

  wb_retire_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd           (in_rd),
    .in_data         (in_data),
    .in_is_load      (in_is_load),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .rs1_D           (rs1_D),
    .rs2_D           (rs2_D),
    .stall_load_use  (stall_load_use),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .RegWrite_riseW  (RegWrite_riseW),
    .Rd_riseW        (Rd_riseW),
    .rdata_reg_riseW (rdata_reg_riseW),
    .RegWrite_buf2   (RegWrite_buf2),
    .Rd_buf2         (Rd_buf2),
    .rdata_reg_buf2  (rdata_reg_buf2),
    .err_orphan      (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic ld);
    in_valid = v; in_rd = rd; in_data = d; in_is_load = ld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    mem_rvalid = 1'b0; mem_rdata = 32'h0; rs1_D = 5'd0; rs2_D = 5'd0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    checks++; if ({RegWrite_riseW, Rd_riseW, rdata_reg_riseW} !== 38'h0) begin errors++; $display("FAIL reset_riseW got %b/%0d/%h exp 0", RegWrite_riseW, Rd_riseW, rdata_reg_riseW); end
    checks++; if ({RegWrite_buf2, Rd_buf2, rdata_reg_buf2} !== 38'h0) begin errors++; $display("FAIL reset_buf2 got %b/%0d/%h exp 0", RegWrite_buf2, Rd_buf2, rdata_reg_buf2); end
    checks++; if (stall_load_use !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_load_use); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", err_orphan); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_alu_write();
    drive(1'b1, 5'd5, 32'h1234, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", in_ready); end
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin errors++; $display("FAIL alu_write got we=%b a=%0d d=%h exp we=1 a=5 d=1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if ({RegWrite_riseW, Rd_riseW, rdata_reg_riseW} !== {1'b1, 5'd5, 32'h1234}) begin errors++; $display("FAIL alu_riseW got %b/%0d/%h exp 1/5/1234", RegWrite_riseW, Rd_riseW, rdata_reg_riseW); end
    cyc();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_drained got %b exp 0", rf_we); end
  endtask

  task automatic test_x0_discard();
    drive(1'b1, 5'd0, 32'hFF, 1'b0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checks++; if ({rf_we, RegWrite_riseW} !== 2'b00) begin errors++; $display("FAIL x0_discard got we=%b riseW=%b exp 0/0", rf_we, RegWrite_riseW); end
    cyc();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd7, 32'hDEAD, 1'b1);
    rs1_D = 5'd7;
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checks++; if ({stall_load_use, rf_we} !== 2'b10) begin errors++; $display("FAIL lu_t1 got stall=%b we=%b exp 1/0", stall_load_use, rf_we); end
    cyc();
    checks++; if (stall_load_use !== 1'b1) begin errors++; $display("FAIL lu_t2 got stall=%b exp 1", stall_load_use); end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    checks++; if ({stall_load_use, rf_we} !== 2'b10) begin errors++; $display("FAIL lu_t3 got stall=%b we=%b exp 1/0", stall_load_use, rf_we); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hCAFE}) begin errors++; $display("FAIL lu_write got we=%b a=%0d d=%h exp 1/7/cafe", rf_we, rf_waddr, rf_wdata); end
    checks++; if (stall_load_use !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got %b exp 0", stall_load_use); end
    rs1_D = 5'd0;
    cyc();
  endtask

  task automatic test_order();
    drive(1'b1, 5'd3, 32'h0, 1'b1);
    rs2_D = 5'd3;
    cyc();
    drive(1'b1, 5'd3, 32'h11, 1'b0);
    #1;
    checks++; if ({stall_load_use, rf_we, RegWrite_riseW} !== 3'b100) begin errors++; $display("FAIL ord_t1 got stall=%b we=%b riseW=%b exp 1/0/0", stall_load_use, rf_we, RegWrite_riseW); end
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checks++; if ({stall_load_use, rf_we, RegWrite_buf2} !== 3'b100) begin errors++; $display("FAIL ord_blocked got stall=%b we=%b buf2=%b exp 1/0/0", stall_load_use, rf_we, RegWrite_buf2); end
    checks++; if ({RegWrite_riseW, Rd_riseW, rdata_reg_riseW} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL ord_riseW got %b/%0d/%h exp 1/3/11", RegWrite_riseW, Rd_riseW, rdata_reg_riseW); end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ord_fill_cycle got we=%b exp 0", rf_we); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hBEEF}) begin errors++; $display("FAIL ord_first got we=%b a=%0d d=%h exp 1/3/beef", rf_we, rf_waddr, rf_wdata); end
    checks++; if ({RegWrite_buf2, Rd_buf2, rdata_reg_buf2} !== {1'b1, 5'd3, 32'hBEEF}) begin errors++; $display("FAIL ord_buf2 got %b/%0d/%h exp 1/3/beef", RegWrite_buf2, Rd_buf2, rdata_reg_buf2); end
    checks++; if (stall_load_use !== 1'b0) begin errors++; $display("FAIL ord_stall_drop got %b exp 0", stall_load_use); end
    cyc();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL ord_second got we=%b a=%0d d=%h exp 1/3/11", rf_we, rf_waddr, rf_wdata); end
    cyc();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ord_drained got %b exp 0", rf_we); end
    rs2_D = 5'd0;
  endtask

  task automatic test_full();
    drive(1'b1, 5'd8, 32'h0, 1'b1);
    cyc();
    drive(1'b1, 5'd9, 32'h0, 1'b1);
    cyc();
    drive(1'b1, 5'd10, 32'hA, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h88;
    #1;
    checks++; if ({in_ready, rf_we} !== 2'b00) begin errors++; $display("FAIL full_block got ready=%b we=%b exp 0/0", in_ready, rf_we); end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_retire_ready got %b exp 1", in_ready); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88}) begin errors++; $display("FAIL full_head got we=%b a=%0d d=%h exp 1/8/88", rf_we, rf_waddr, rf_wdata); end
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checks++; if ({in_ready, rf_we} !== 2'b00) begin errors++; $display("FAIL full_count2 got ready=%b we=%b exp 0/0", in_ready, rf_we); end
    checks++; if ({RegWrite_riseW, Rd_riseW, rdata_reg_riseW} !== {1'b1, 5'd10, 32'hA}) begin errors++; $display("FAIL full_riseW got %b/%0d/%h exp 1/10/a", RegWrite_riseW, Rd_riseW, rdata_reg_riseW); end
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin errors++; $display("FAIL full_x9 got we=%b a=%0d d=%h exp 1/9/99", rf_we, rf_waddr, rf_wdata); end
    cyc();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA}) begin errors++; $display("FAIL full_x10 got we=%b a=%0d d=%h exp 1/10/a", rf_we, rf_waddr, rf_wdata); end
    cyc();
    checks++; if ({rf_we, in_ready, err_orphan} !== 3'b010) begin errors++; $display("FAIL full_drained got we=%b ready=%b orphan=%b exp 0/1/0", rf_we, in_ready, err_orphan); end
  endtask

  task automatic test_orphan_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
    drive(1'b1, 5'd4, 32'h0, 1'b1);
    rs1_D = 5'd4;
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    checks++; if ({err_orphan, stall_load_use} !== 2'b11) begin errors++; $display("FAIL orphan_sticky got orphan=%b stall=%b exp 1/1", err_orphan, stall_load_use); end
    rst_n = 1'b0;
    #1;
    checks++; if ({err_orphan, stall_load_use, in_ready, rf_we} !== 4'b0010) begin errors++; $display("FAIL async_reset got orphan=%b stall=%b ready=%b we=%b exp 0/0/1/0", err_orphan, stall_load_use, in_ready, rf_we); end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++; if ({rf_we, stall_load_use, RegWrite_riseW, RegWrite_buf2} !== 4'b0000) begin errors++; $display("FAIL post_reset got we=%b stall=%b riseW=%b buf2=%b exp 0", rf_we, stall_load_use, RegWrite_riseW, RegWrite_buf2); end
    rs1_D = 5'd0;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_x0_discard();
    test_load_use();
    test_order();
    test_full();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got no finish exp finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
